// File: rtl/linear_mac.sv
// Fully-connected layer MAC: streams IN_DIM feature/weight pairs per neuron into a 72-bit
// accumulator and emits one saturated Q8.24 result per neuron. Define LINEAR_MAC_RELU_EN to clamp negative results to zero.
module linear_mac #(
  parameter int IN_DIM  = 40,
  parameter int OUT_DIM = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [5:0]  feat_addr,
  input  logic [31:0] feat_data,
  output logic [8:0]  w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_e;

  localparam logic [5:0] LAST_I = 6'(IN_DIM - 1);
  localparam logic [3:0] LAST_O = 4'(OUT_DIM - 1);
  localparam logic signed [71:0] SAT_MAX = 72'sd2147483647;
  localparam logic signed [71:0] SAT_MIN = -72'sd2147483648;

  state_e             state_q, state_d;
  logic [3:0]         o_q, o_d;
  logic [5:0]         feat_addr_q, feat_addr_d;
  logic [8:0]         w_addr_q, w_addr_d;
  logic [1:0]         drain_q, drain_d;
  logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [31:0] fd_q, fd_d, wd_q, wd_d;
  logic signed [63:0] prod_q, prod_d;
  logic signed [71:0] acc_q, acc_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [3:0]         out_idx_q, out_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic signed [71:0] acc_shr;
  logic [31:0]        result;

  // Truncating shift back to Q8.24, then clamp into the signed 32-bit range.
  always_comb begin
    acc_shr = acc_q >>> 24;
    if (acc_shr > SAT_MAX)      result = 32'h7FFF_FFFF;
    else if (acc_shr < SAT_MIN) result = 32'h8000_0000;
    else                        result = acc_shr[31:0];
`ifdef LINEAR_MAC_RELU_EN
    if (result[31]) result = 32'h0000_0000;
`else
    result = result;
`endif
  end

  // Result handshake: a result transfers on a cycle where out_valid && out_ready; out_valid never
  // drops and out_data/out_idx never change until that transfer has happened.
  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    feat_addr_d = feat_addr_q;
    w_addr_d    = w_addr_q;
    drain_d     = drain_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    // Valid bits follow each issued address through data, product and accumulate stages.
    v1_d   = (state_q == ISSUE);
    v2_d   = v1_q;
    v3_d   = v2_q;
    fd_d   = v1_q ? feat_data : fd_q;
    wd_d   = v1_q ? w_data : wd_q;
    prod_d = fd_q * wd_q;
    acc_d  = v3_q ? acc_q + {{8{prod_q[63]}}, prod_q} : acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          o_d         = 4'd0;
          feat_addr_d = 6'd0;
          w_addr_d    = 9'd0;
          acc_d       = '0;
        end
      end
      ISSUE: begin
        if (feat_addr_q == LAST_I) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end else begin
          feat_addr_d = feat_addr_q + 6'd1;
          w_addr_d    = w_addr_q + 9'd1;
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) state_d = OUT;
        else                 drain_d = drain_q + 2'd1;
      end
      OUT: begin
        if (!out_valid_q) begin
          // First OUT cycle: the last product has just landed in the accumulator.
          out_valid_d = 1'b1;
          out_data_d  = result;
          out_idx_d   = o_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          if (o_q == LAST_O) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = ISSUE;
            o_d         = o_q + 4'd1;
            feat_addr_d = 6'd0;
            w_addr_d    = w_addr_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      o_q         <= '0;
      feat_addr_q <= '0;
      w_addr_q    <= '0;
      drain_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      fd_q        <= '0;
      wd_q        <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      feat_addr_q <= feat_addr_d;
      w_addr_q    <= w_addr_d;
      drain_q     <= drain_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      fd_q        <= fd_d;
      wd_q        <= wd_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign feat_addr = feat_addr_q;
  assign w_addr    = w_addr_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_linear_mac.sv
// Self-checking bench for linear_mac: synchronous feature/weight memories, a sum-of-products
// reference model and directed layer runs with stalls, saturation and mid-layer reset.
module tb_linear_mac;
  localparam int IN_DIM  = 40;
  localparam int OUT_DIM = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [5:0]  feat_addr;
  logic [31:0] feat_data = '0;
  logic [8:0]  w_addr;
  logic [31:0] w_data = '0;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid, busy, done;
  logic [1:0]  dbg_state;

  logic [31:0] feat_mem[64];
  logic [31:0] w_mem[512];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_total = 0;

  linear_mac #(.IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .feat_addr(feat_addr), .feat_data(feat_data),
    .w_addr(w_addr), .w_data(w_data),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and synchronous memories (data one cycle after address)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    feat_data <= feat_mem[feat_addr];
    w_data    <= w_mem[w_addr];
  end

  always @(negedge clk) if (done) done_total++;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum of signed Q8.24 products, floor to Q8.24, clamp to 32-bit signed.
  function automatic logic [31:0] model(input int n);
    logic signed [79:0] sum;
    logic signed [63:0] p;
    logic signed [79:0] q;
    logic [31:0]        r;
    sum = '0;
    for (int i = 0; i < IN_DIM; i++) begin
      p   = $signed(feat_mem[i]) * $signed(w_mem[n * IN_DIM + i]);
      sum = sum + p;
    end
    q = sum >>> 24;
    if (q > 80'sd2147483647)       r = 32'h7FFF_FFFF;
    else if (q < -80'sd2147483648) r = 32'h8000_0000;
    else                           r = q[31:0];
`ifdef LINEAR_MAC_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  task automatic fill_const(input logic [31:0] f, input logic [31:0] w);
    for (int i = 0; i < 64; i++) feat_mem[i] = f;
    for (int i = 0; i < 512; i++) w_mem[i] = w;
  endtask

  // Values in roughly [-1.0, +1.0) keep sums unsaturated; wide=1 uses full-range words.
  task automatic fill_rand(input bit wide);
    for (int i = 0; i < 64; i++)
      feat_mem[i] = wide ? $urandom : $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
    for (int i = 0; i < 512; i++)
      w_mem[i] = wide ? $urandom : $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_feat_addr"}, 32'(feat_addr), 32'd0);
    check32({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check32({tag, "_out_data"}, out_data, 32'd0);
    check32({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check32({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check32({tag, "_busy"}, 32'(busy), 32'd0);
    check32({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Driver: one full layer, called at a negedge with start/out_ready low.
  task automatic run_layer(input int stall_max, input bit chk_addr, input bit stall5, input bit dbl_start);
    int k;
    int st;
    int done_base;
    logic [31:0] e;
    exp_q.delete();
    for (int o = 0; o < OUT_DIM; o++) exp_q.push_back(model(o));
    done_base = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < OUT_DIM; n++) begin
      k = 0;
      while (!out_valid && k < 200) begin
        if (chk_addr && n == 3 && k < IN_DIM) begin
          check32("n3_feat_addr", 32'(feat_addr), 32'(k));
          check32("n3_w_addr", 32'(w_addr), 32'(3 * IN_DIM + k));
        end
        if (dbl_start && n == 0) start = (k == 5);
        @(negedge clk);
        k++;
      end
      start = 1'b0;
      check32("latency", 32'(k), 32'(IN_DIM + 4));
      if (!out_valid) return;
      e = exp_q.pop_front();
      if (stall5 && n == 2) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check32("stall_valid", 32'(out_valid), 32'd1);
          check32("stall_data", out_data, e);
          check32("stall_w_addr", 32'(w_addr), 32'(3 * IN_DIM - 1));
        end
      end else begin
        st = $urandom_range(0, stall_max);
        repeat (st) @(negedge clk);
      end
      check32("out_data", out_data, e);
      check32("out_idx", 32'(out_idx), 32'(n));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (n < OUT_DIM - 1) begin
        check32("next_w_addr", 32'(w_addr), 32'((n + 1) * IN_DIM));
        check32("next_busy", 32'(busy), 32'd1);
      end else begin
        check32("done_pulse", 32'(done), 32'd1);
        check32("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check32("done_clear", 32'(done), 32'd0);
      end
    end
    check32("done_count", 32'(done_total - done_base), 32'd1);
  endtask

  initial begin
    int k;
    fill_const(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform weights 1.0 and features 0.5: every neuron sums to 20.0
    fill_const(32'h0080_0000, 32'h0100_0000);
    run_layer(0, 1'b1, 1'b0, 1'b0);

    fill_rand(1'b0);
    run_layer(3, 1'b1, 1'b0, 1'b0);
    fill_rand(1'b0);
    run_layer(2, 1'b0, 1'b0, 1'b0);
    fill_rand(1'b1);
    run_layer(1, 1'b0, 1'b0, 1'b0);

    // Saturation both ways and negative results
    fill_const(32'h7F00_0000, 32'h7F00_0000);
    run_layer(0, 1'b0, 1'b0, 1'b0);
    fill_const(32'h8100_0000, 32'h7F00_0000);
    run_layer(0, 1'b0, 1'b0, 1'b0);
    fill_const(32'h0080_0000, 32'hFF00_0000);
    run_layer(0, 1'b0, 1'b1, 1'b0);

    // Reset while neuron 4 is issuing, then a fresh layer with a spurious second start
    fill_rand(1'b0);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (w_addr != 9'(4 * IN_DIM + 5) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check32("reach_n4", 32'(w_addr), 32'(4 * IN_DIM + 5));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    run_layer(3, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linear_mac.md
LINEAR_MAC -- requirements
Module: linear_mac

Interface
REQ-001 Parameter IN_DIM, default 40, is the number of input features per neuron (1..64).
REQ-002 Parameter OUT_DIM, default 10, is the number of output neurons (1..16); IN_DIM*OUT_DIM SHALL be <= 512.
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run a full layer; sampled only in IDLE.
REQ-006 feat_addr  output  6  feature buffer read address.
REQ-007 feat_data  input  32  signed Q8.24 feature, valid one cycle after feat_addr.
REQ-008 w_addr  output  9  weight ROM read address.
REQ-009 w_data  input  32  signed Q8.24 weight, valid one cycle after w_addr.
REQ-010 out_data  output  32  signed Q8.24 neuron result.
REQ-011 out_idx  output  4  neuron index of out_data.
REQ-012 out_valid  output  1  out_data/out_idx valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the last result is accepted.

Function
REQ-016 The block SHALL use FSM states IDLE, ISSUE, DRAIN and OUT.
REQ-017 IDLE -> ISSUE SHALL occur on start=1; neuron counter o and input counter i SHALL be cleared and the accumulator zeroed.
REQ-018 In ISSUE, each cycle SHALL drive feat_addr=i and w_addr=o*IN_DIM+i (row-major), increment i, and move to DRAIN after i=IN_DIM-1.
REQ-019 The pipeline SHALL be: address cycle, data cycle (ROM/buffer register), registered 64-bit signed product, then accumulation into a 72-bit signed accumulator.
REQ-020 DRAIN SHALL last exactly 3 cycles and then enter OUT; first out_valid for a neuron SHALL occur IN_DIM+4 cycles after its first address.
REQ-021 The result SHALL be the accumulator arithmetic-shifted right 24 (truncation), saturated to [0x80000000, 0x7FFFFFFF].
REQ-022 In OUT, out_valid=1 and out_data/out_idx SHALL be held stable until out_valid&out_ready.
REQ-023 On handshake with o<OUT_DIM-1, the block SHALL increment o, clear i and the accumulator, and return to ISSUE on the next cycle.
REQ-024 On handshake with o=OUT_DIM-1, the block SHALL return to IDLE and pulse done for exactly one cycle.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 feat_addr and w_addr SHALL hold their last values outside ISSUE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and drive feat_addr, w_addr, out_data, out_idx, out_valid, busy and done to 0, and clear all counters, pipeline registers and the accumulator.
REQ-028 Reset mid-operation SHALL abandon the layer; the next start SHALL begin at neuron 0.

Configuration
REQ-029 With LINEAR_MAC_RELU_EN defined, negative saturated results SHALL be replaced by 0x00000000 before out_data; without it, signed results SHALL pass unchanged.

Verification
REQ-030 All weights 0x01000000, all features 0x00800000, start -> 10 results of 0x14000000, out_idx 0..9, single done pulse.
REQ-031 Address check: during neuron 3, w_addr steps 120..159 and feat_addr 0..39 on consecutive cycles; out_valid occurs 44 cycles after w_addr=120.
REQ-032 Weights and features 0x7F000000 -> out_data 0x7FFFFFFF; feature 0x81000000 -> 0x80000000 (0x00000000 with LINEAR_MAC_RELU_EN).
REQ-033 Weights 0xFF000000, features 0x00800000 -> 0xEC000000 without the macro, 0x00000000 with it.
REQ-034 out_ready held low 5 cycles in OUT -> out_valid, out_data and w_addr stable; released -> next neuron starts the following cycle.
REQ-035 rst_n low during neuron 4 -> all outputs 0 at once, busy=0; second start while busy ignored; fresh start -> out_idx begins at 0.
